// File: rtl/float_argmax_pkg.sv
// ============================================================================
// Module  : float_argmax_pkg
// Brief   : Shared FSM state encoding and default widths for float_argmax_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package float_argmax_pkg;

    localparam int E_BIT_DEF = 8;
    localparam int F_BIT_DEF = 23;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } argmax_state_e;

endpackage

`default_nettype wire

// File: rtl/float_cmp_reg.sv
// ============================================================================
// Module  : float_cmp_reg
// Brief   : Registered sign-magnitude float comparator, one-cycle latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module float_cmp_reg
    import float_argmax_pkg::*;
#(
    parameter int W = 1 + E_BIT_DEF + F_BIT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    logic w_mag_gt;
    logic w_eq;
    logic w_gt;
    logic w_lt;

    assign w_mag_gt = (a[W-2:0] > b[W-2:0]);
    assign w_eq     = (a == b);

    // NaN/Inf fall out of the plain bit-pattern ordering; +0 and -0 differ by sign.
    always_comb begin
        w_gt = 1'b0;
        w_lt = 1'b0;
        if (a[W-1] != b[W-1]) begin
            w_gt = ~a[W-1];
            w_lt =  a[W-1];
        end else if (!w_eq) begin
            w_gt = a[W-1] ? ~w_mag_gt :  w_mag_gt;
            w_lt = a[W-1] ?  w_mag_gt : ~w_mag_gt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
        end else begin
            gt <= w_gt;
            eq <= w_eq;
            lt <= w_lt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/float_argmax.sv
// ============================================================================
// Module  : float_argmax_seq
// Brief   : Streaming arg-max over a burst of floats, one word per 2 cycles.
//           Optional min tracking enabled by macro FLOAT_ARGMAX_MIN_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module float_argmax_seq
    import float_argmax_pkg::*;
#(
    parameter int E_BIT = E_BIT_DEF,
    parameter int F_BIT = F_BIT_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [E_BIT+F_BIT:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [E_BIT+F_BIT:0]   out_max,
    output logic [IDX_W-1:0]       out_idx,
    output logic [IDX_W-1:0]       out_count,
    output logic                   out_ovf,
    output logic                   busy
`ifdef FLOAT_ARGMAX_MIN_EN
    ,
    output logic [E_BIT+F_BIT:0]   out_min,
    output logic [IDX_W-1:0]       out_min_idx
`endif
);

    localparam int W = 1 + E_BIT + F_BIT;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       r_state;
    logic [W-1:0]     r_best;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_count;
    logic             r_ovf;
    logic [W-1:0]     r_cand;
    logic [IDX_W-1:0] r_cand_idx;
    logic             r_cand_last;

    logic             w_accept;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_max_gt;
    logic             w_max_eq;
    logic             w_max_lt;

    assign in_ready   = ((r_state == IDLE) || (r_state == SCAN)) && !rst;
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_next_idx = (r_count == IDX_MAX) ? IDX_MAX : r_count + 1'b1;

    assign out_max    = r_best;
    assign out_idx    = r_idx;
    assign out_count  = r_count;
    assign out_ovf    = r_ovf;

    // Compares the word being accepted against the running best; read in WAIT.
    float_cmp_reg #(.W(W)) u_cmp_max (
        .clk (clk),
        .rst (rst),
        .a   (in_data),
        .b   (r_best),
        .gt  (w_max_gt),
        .eq  (w_max_eq),
        .lt  (w_max_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_best      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_cand      <= '0;
            r_cand_idx  <= '0;
            r_cand_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_best  <= in_data;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= in_last ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (w_accept) begin
                        r_cand      <= in_data;
                        r_cand_idx  <= w_next_idx;
                        r_cand_last <= in_last;
                        if (r_count == IDX_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Strictly greater only, so ties keep the earliest index.
                    if (w_max_gt) begin
                        r_best <= r_cand;
                        r_idx  <= r_cand_idx;
                    end
                    r_state <= r_cand_last ? DONE : SCAN;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef FLOAT_ARGMAX_MIN_EN
    logic [W-1:0]     r_min;
    logic [IDX_W-1:0] r_min_idx;
    logic             w_min_gt;
    logic             w_min_eq;
    logic             w_min_lt;

    assign out_min     = r_min;
    assign out_min_idx = r_min_idx;

    float_cmp_reg #(.W(W)) u_cmp_min (
        .clk (clk),
        .rst (rst),
        .a   (in_data),
        .b   (r_min),
        .gt  (w_min_gt),
        .eq  (w_min_eq),
        .lt  (w_min_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min     <= '0;
            r_min_idx <= '0;
        end else if ((r_state == IDLE) && w_accept) begin
            r_min     <= in_data;
            r_min_idx <= '0;
        end else if ((r_state == WAIT) && w_min_lt) begin
            r_min     <= r_cand;
            r_min_idx <= r_cand_idx;
        end
    end
`endif

endmodule

`default_nettype wire
